// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: S-box, GF(2^8) doubling, FSM states.
package aes_pkg;

  localparam int KEY_BITS_128 = 128;
  localparam int KEY_BITS_192 = 192;
  localparam int KEY_BITS_256 = 256;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_e;

  // Entry 0 sits in the top byte so the table reads in natural order.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    idx = ~{x, 3'b000};
    return SBOX_FLAT[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: S-box applied to each byte of a 32-bit word.
module sub_word import aes_pkg::*; (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES key expansion, one word per clock, with a buffered
// round-key read port.
module aes_key_schedule import aes_pkg::*; #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  input  logic                rd_en,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic                rd_valid
);

  localparam int NK          = KEY_BITS / 32;
  localparam int NR          = NK + 6;
  localparam int TOTAL_WORDS = 4 * (NR + 1);

  if (KEY_BITS != KEY_BITS_128 && KEY_BITS != KEY_BITS_192 &&
      KEY_BITS != KEY_BITS_256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  ks_state_e   state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  kpos_q, kpos_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w_q [TOTAL_WORDS];

  logic        start_acc, wr_en, rot;
  logic [31:0] prev_w, sub_in, sub_out, temp, new_w;

  assign start_acc = start && (state_q != EXPAND);
  assign busy      = (state_q == EXPAND);
  assign done      = (state_q == DONE);

  // kpos tracks i mod NK so the 192-bit case avoids a divider.
  assign prev_w = w_q[idx_q - 6'd1];
  assign rot    = (kpos_q == 3'd0);
  assign sub_in = rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    temp = prev_w;
    if (rot)                             temp = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && kpos_q == 3'd4)  temp = sub_out;
  end

  assign new_w = w_q[idx_q - 6'(NK)] ^ temp;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kpos_d  = kpos_q;
    rcon_d  = rcon_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = EXPAND;
          idx_d   = 6'(NK);
          kpos_d  = 3'd0;
          rcon_d  = RCON_INIT;
        end
      end
      EXPAND: begin
        wr_en  = 1'b1;
        idx_d  = idx_q + 6'd1;
        kpos_d = (kpos_q == 3'(NK - 1)) ? 3'd0 : kpos_q + 3'd1;
        if (rot) rcon_d = xtime(rcon_q);
        if (idx_q == 6'(TOTAL_WORDS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      kpos_q  <= '0;
      rcon_q  <= RCON_INIT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kpos_q  <= kpos_d;
      rcon_q  <= rcon_d;
    end
  end

  // Buffer is deliberately not cleared by reset; only writes are gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (start_acc) begin
        for (int j = 0; j < NK; j++) w_q[j] <= key_in[KEY_BITS-1-32*j -: 32];
      end else if (wr_en) begin
        w_q[idx_q] <= new_w;
      end
    end
  end

  logic       rd_ok;
  logic [3:0] rd_r;
  logic [5:0] rd_base;
  logic [127:0] rd_key_q;
  logic         rd_valid_q;

  // A restart on the same edge wins over a read of the old schedule.
  assign rd_ok   = (state_q == DONE) && (rd_round <= 4'(NR)) && !start_acc;
  assign rd_r    = rd_ok ? rd_round : 4'd0;
  assign rd_base = {rd_r, 2'b00};

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en && rd_ok;
      if (rd_en)
        rd_key_q <= rd_ok ? {w_q[rd_base], w_q[rd_base + 6'd1],
                             w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} : '0;
    end
  end

  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Runs 128/192/256-bit schedulers side by side from shared controls and
// checks handshake timing and round-key reads against a scoreboard.
module tb_aes_key_schedule;
  import aes_pkg::*;

  typedef struct {
    logic [2:0]        vld;
    logic [2:0][127:0] key;
  } rd_exp_t;

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic reset, start, rd_en;
  logic [3:0] rd_round;
  logic [127:0] key128;
  logic [191:0] key192;
  logic [255:0] key256;
  logic [2:0] busy, done, rdv;
  logic [2:0][127:0] rk;

  logic [2:0][255:0] mkey;
  rd_exp_t sbq[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_key_schedule #(.KEY_BITS(128)) u_k128 (
    .clk(clk), .reset(reset), .start(start), .key_in(key128),
    .busy(busy[0]), .done(done[0]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk[0]), .rd_valid(rdv[0]));
  aes_key_schedule #(.KEY_BITS(192)) u_k192 (
    .clk(clk), .reset(reset), .start(start), .key_in(key192),
    .busy(busy[1]), .done(done[1]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk[1]), .rd_valid(rdv[1]));
  aes_key_schedule #(.KEY_BITS(256)) u_k256 (
    .clk(clk), .reset(reset), .start(start), .key_in(key256),
    .busy(busy[2]), .done(done[2]), .rd_en(rd_en), .rd_round(rd_round),
    .rd_key(rk[2]), .rd_valid(rdv[2]));

  function automatic logic [31:0] sw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Reference expansion; key is left-aligned in 256 bits.
  function automatic logic [127:0] model_rk(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic rd_exp_t exp_read(input int r, input logic [2:0] dn);
    rd_exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (dn[k] && r <= 10 + 2 * k) begin
        e.vld[k] = 1'b1;
        e.key[k] = model_rk(mkey[k], 4 + 2 * k, r);
      end else begin
        e.vld[k] = 1'b0;
        e.key[k] = '0;
      end
    end
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input logic [127:0] a, input logic [191:0] b, input logic [255:0] c);
    key128 = a; key192 = b; key256 = c;
    mkey[0] = {a, 128'h0};
    mkey[1] = {b, 64'h0};
    mkey[2] = c;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; rd_en = 1'b1; rd_round = 4'd0;
    load_keys('0, '0, '0);
    repeat (2) tick;
    checks++; if (busy !== 3'b000) begin failures++; $display("FAIL reset_busy got=%b exp=000", busy); end
    checks++; if (done !== 3'b000) begin failures++; $display("FAIL reset_done got=%b exp=000", done); end
    checks++; if (rdv !== 3'b000) begin failures++; $display("FAIL reset_rd_valid got=%b exp=000", rdv); end
    checks++; if (rk !== '0) begin failures++; $display("FAIL reset_rd_key got=%h exp=0", rk); end
    rd_en = 1'b0; reset = 1'b1;
    tick;
  endtask

  // Expansion timing, a read while busy, and a start pulse that must be ignored.
  task automatic test_expand;
    rd_exp_t e;
    logic [2:0] dn;
    load_keys(K128, K192, K256);
    start = 1'b1; tick; start = 1'b0;
    checks++; if (busy !== 3'b111 || done !== 3'b000) begin
      failures++; $display("FAIL start_edge busy=%b done=%b exp busy=111 done=000", busy, done);
    end
    for (int n = 1; n <= 52; n++) begin
      if (n == 5) begin rd_en = 1'b1; rd_round = 4'd1; sbq.push_back(exp_read(1, 3'b000)); end
      if (n == 10) start = 1'b1;
      tick;
      start = 1'b0;
      if (rd_en) begin
        rd_en = 1'b0;
        e = sbq.pop_front();
        checks++; if (rdv !== e.vld || rk !== e.key) begin
          failures++; $display("FAIL busy_read vld=%b key=%h exp vld=%b key=%h", rdv, rk, e.vld, e.key);
        end
      end
      dn = {n >= 52, n >= 46, n >= 40};
      checks++; if (done !== dn || busy !== ~dn) begin
        failures++; $display("FAIL done_timing n=%0d done=%b busy=%b exp done=%b", n, done, busy, dn);
      end
    end
  endtask

  // Back-to-back reads over every round index, including out-of-range ones.
  task automatic test_readout;
    rd_exp_t e;
    rd_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rd_round = 4'(r);
      sbq.push_back(exp_read(r, 3'b111));
      tick;
      e = sbq.pop_front();
      checks++; if (rdv !== e.vld || rk !== e.key) begin
        failures++; $display("FAIL read r=%0d vld=%b key=%h exp vld=%b key=%h", r, rdv, rk, e.vld, e.key);
      end
      if (r == 1) begin
        checks++; if (rk[0] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          failures++; $display("FAIL vec128_r1 got=%h", rk[0]); end
      end
      if (r == 10) begin
        checks++; if (rk[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
          failures++; $display("FAIL vec128_r10 got=%h", rk[0]); end
      end
      if (r == 12) begin
        checks++; if (rk[1] !== 128'he98ba06f448c773c8ecc720401002202) begin
          failures++; $display("FAIL vec192_r12 got=%h", rk[1]); end
      end
      if (r == 14) begin
        checks++; if (rk[2] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
          failures++; $display("FAIL vec256_r14 got=%h", rk[2]); end
      end
    end
    rd_round = 4'd3;
    sbq.push_back(exp_read(3, 3'b111));
    tick;
    rd_en = 1'b0;
    e = sbq.pop_front();
    tick;
    checks++; if (rdv !== 3'b000 || rk !== e.key) begin
      failures++; $display("FAIL read_hold vld=%b key=%h exp vld=000 key=%h", rdv, rk, e.key);
    end
  endtask

  // Restart from DONE with a coincident read, then read the new schedule.
  task automatic test_restart;
    rd_exp_t e;
    load_keys('0, '0, '0);
    start = 1'b1; rd_en = 1'b1; rd_round = 4'd2;
    sbq.push_back(exp_read(2, 3'b000));
    tick;
    start = 1'b0; rd_en = 1'b0;
    e = sbq.pop_front();
    checks++; if (rdv !== e.vld || rk !== e.key) begin
      failures++; $display("FAIL restart_read vld=%b key=%h exp vld=000 key=0", rdv, rk);
    end
    checks++; if (done !== 3'b000 || busy !== 3'b111) begin
      failures++; $display("FAIL restart_edge done=%b busy=%b exp done=000 busy=111", done, busy);
    end
    repeat (52) tick;
    checks++; if (done !== 3'b111) begin failures++; $display("FAIL restart_done got=%b exp=111", done); end
    rd_en = 1'b1;
    for (int r = 1; r <= 2; r++) begin
      rd_round = 4'(r);
      sbq.push_back(exp_read(r, 3'b111));
      tick;
      e = sbq.pop_front();
      checks++; if (rdv !== e.vld || rk !== e.key) begin
        failures++; $display("FAIL restart_read r=%0d key=%h exp=%h", r, rk, e.key);
      end
      checks++; if (rk[0] !== (r == 1 ? 128'h62636363626363636263636362636363
                                       : 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa)) begin
        failures++; $display("FAIL zero_key_r%0d got=%h", r, rk[0]);
      end
    end
    rd_en = 1'b0;
    tick;
  endtask

  // Reset in the middle of an expansion, then a clean rerun.
  task automatic test_reset_mid;
    rd_exp_t e;
    int n;
    load_keys(K128, K192, K256);
    start = 1'b1; tick; start = 1'b0;
    repeat (20) tick;
    reset = 1'b0; rd_en = 1'b1; rd_round = 4'd0;
    tick;
    reset = 1'b1; rd_en = 1'b0;
    checks++; if (busy !== 3'b000 || done !== 3'b000 || rdv !== 3'b000) begin
      failures++; $display("FAIL mid_reset busy=%b done=%b vld=%b exp all 000", busy, done, rdv);
    end
    repeat (5) tick;
    checks++; if (busy !== 3'b000 || done !== 3'b000) begin
      failures++; $display("FAIL post_reset_idle busy=%b done=%b exp 000", busy, done);
    end
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!done[0] && n < 100) begin tick; n++; end
    checks++; if (n !== 40) begin failures++; $display("FAIL rerun_latency got=%0d exp=40", n); end
    while (done !== 3'b111 && n < 100) begin tick; n++; end
    checks++; if (done !== 3'b111) begin failures++; $display("FAIL rerun_done got=%b exp=111", done); end
    rd_en = 1'b1;
    for (int r = 0; r <= 14; r++) begin
      rd_round = 4'(r);
      sbq.push_back(exp_read(r, 3'b111));
      tick;
      e = sbq.pop_front();
      checks++; if (rdv !== e.vld || rk !== e.key) begin
        failures++; $display("FAIL rerun_read r=%0d vld=%b key=%h exp vld=%b key=%h", r, rdv, rk, e.vld, e.key);
      end
    end
    rd_en = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_expand;
    test_readout;
    test_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
